// File: rtl/pipelined_adder_arbiter_pkg.sv
// Shared types and defaults for the round-robin front end of pipelined_adder.
// The tag type carries a requester id alongside each operation in flight.
package pipelined_adder_arb_pkg;

    localparam int ADDER_WIDTH       = 26;
    localparam int ARB_MAX_REQ       = 8;
    localparam int ADDER_LATENCY_DEF = 3;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } adder_tag_t;

endpackage

// File: rtl/pipelined_adder_arbiter_if.sv
// Requester, adder and response signals of pipelined_adder_arbiter.
// The master side is the requesters plus the adder, the slave side the arbiter.
interface pipelined_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 26
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_op_a;
    logic [NUM_REQ*WIDTH-1:0] req_op_b;
    logic [WIDTH-1:0]         add_op_a;
    logic [WIDTH-1:0]         add_op_b;
    logic [WIDTH-1:0]         add_out;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_op_a, req_op_b, add_out,
        input  req_ready, add_op_a, add_op_b, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, add_out,
        output req_ready, add_op_a, add_op_b, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/pipelined_adder_arbiter_tag_pipe.sv
// adder_tag_pipe: fixed-depth shift register of requester tags, cleared by the
// synchronous reset so nothing in flight survives it.
module adder_tag_pipe
    import pipelined_adder_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock0,
    input  logic       reset,
    input  adder_tag_t tag_in,
    output adder_tag_t tag_out
);
    adder_tag_t stage_d [DEPTH];
    adder_tag_t stage_q [DEPTH];

    // Shift by one stage per cycle; a bubble enters whenever tag_in is invalid.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Tag stage registers.
    always_ff @(posedge clock0) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];
endmodule

// File: rtl/pipelined_adder_arbiter.sv
// pipelined_adder_arbiter: shares one pipelined_adder between NUM_REQ requesters,
// tagging each issue so the sum returns to its owner. PIPELINED_ADDER_ARB_FIXED_PRIO_EN
// selects fixed priority (requester 0 highest) instead of round-robin.
module pipelined_adder_arbiter
    import pipelined_adder_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = ADDER_WIDTH,
    parameter int ADDER_LATENCY = ADDER_LATENCY_DEF
) (
    input logic                      clock0,
    input logic                      reset,
    pipelined_adder_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    prio_base_s;
    logic               grant_any_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    int                 cand_s;
    logic [WIDTH-1:0]   op_a_d;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_d;
    logic [WIDTH-1:0]   op_b_q;
    adder_tag_t         tag_in_s;
    adder_tag_t         tag_out_s;

    // First valid requester found walking upward from the priority base, with wrap.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = (int'(prio_base_s) + k >= NUM_REQ) ? int'(prio_base_s) + k - NUM_REQ
                                                         : int'(prio_base_s) + k;
            if (!grant_any_s && !reset && bus.req_valid[cand_s[ID_W-1:0]]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s[ID_W-1:0];
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // One-hot grant vector.
    always_comb begin
        if (grant_any_s) begin
            grant_s = NUM_REQ'(1) << grant_idx_s;
        end else begin
            grant_s = '0;
        end
    end

    // Operand capture and tag issue on handshake; operands hold otherwise.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        tag_in_s = '0;
        if (grant_any_s) begin
            op_a_d         = bus.req_op_a[grant_idx_s*WIDTH +: WIDTH];
            op_b_d         = bus.req_op_b[grant_idx_s*WIDTH +: WIDTH];
            tag_in_s.valid = 1'b1;
            tag_in_s.id    = 3'(grant_idx_s);
        end else begin
            tag_in_s.valid = 1'b0;
        end
    end

    // Operand registers feeding the adder.
    always_ff @(posedge clock0) begin
        if (reset) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
        end
    end

`ifdef PIPELINED_ADDER_ARB_FIXED_PRIO_EN
    assign prio_base_s = '0;
`else
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] ptr_q;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        if (grant_any_s) begin
            ptr_d = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock0) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prio_base_s = ptr_q;
`endif

    // One extra stage covers the operand register in front of the adder.
    adder_tag_pipe #(
        .DEPTH (ADDER_LATENCY + 1)
    ) u_tag_pipe (
        .clock0  (clock0),
        .reset   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.add_op_a  = op_a_q;
    assign bus.add_op_b  = op_b_q;
    assign bus.rsp_data  = bus.add_out;
    assign bus.rsp_valid = tag_out_s.valid ? (NUM_REQ'(1) << tag_out_s.id) : '0;
    assign bus.rsp_id    = tag_out_s.valid ? ID_W'(tag_out_s.id) : '0;
endmodule
